// File: rtl/barrier_sched.sv
`default_nettype none
// ============================================================================
// Module   : barrier_sched
// Purpose  : Obstacle-lane controller for the jump game. Owns the 8-bit
//            visible barrier window and the scroll timebase. It inserts
//            obstacles from a random bit while enforcing a minimum gap,
//            detects player collisions, keeps the score and raises the
//            speed level.
// Ports    : clk, rst (sync, active-high), start, jump_air, rand_bit,
//            [pause when BARRIER_PAUSE_EN is defined]
//            barrier[7:0], scroll_tick, running, game_over,
//            score[15:0], level[3:0]
// Options  : BARRIER_PAUSE_EN - adds a `pause` input. While it is high in
//            RUN, the scroll freezes and collisions are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module barrier_sched #(
    parameter int DIV_W         = 24,
    parameter int DIV_INIT      = 5_000_000,
    parameter int DIV_MIN       = 1_000_000,
    parameter int DIV_STEP      = 250_000,
    parameter int MIN_GAP       = 3,
    parameter int SPEEDUP_EVERY = 8,
    parameter int PLAYER_COL    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        jump_air,
    input  logic        rand_bit,
`ifdef BARRIER_PAUSE_EN
    input  logic        pause,
`endif
    output logic [7:0]  barrier,
    output logic        scroll_tick,
    output logic        running,
    output logic        game_over,
    output logic [15:0] score,
    output logic [3:0]  level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] c_div_init = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] c_div_min  = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] c_div_step = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
    localparam logic [3:0]       c_min_gap  = 4'(MIN_GAP);
    localparam logic [15:0]      c_speedup  = 16'(SPEEDUP_EVERY);

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_cur_div;
    logic [3:0]       r_gap_cnt;
    logic [7:0]       r_barrier;
    logic [15:0]      r_score;
    logic [3:0]       r_level;
    logic             r_tick;
    logic             r_running;
    logic             r_game_over;

    logic             w_pause;
    logic             w_collision;
    logic             w_div_end;
    logic             w_new_bit;
    logic             w_score_hit;
    logic [15:0]      w_score_next;
    logic             w_level_up;
    logic [DIV_W-1:0] w_div_dec;

`ifdef BARRIER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // A pause masks both the divider and the collision check.
    assign w_collision = (r_state == S_RUN) && !w_pause
                         && r_barrier[PLAYER_COL] && !jump_air;
    assign w_div_end   = (r_state == S_RUN) && !w_pause
                         && (r_div_cnt >= r_cur_div - c_div_one);

    assign w_new_bit    = rand_bit && (r_gap_cnt >= c_min_gap);
    // No increment once saturated, so no spurious level-up either.
    assign w_score_hit  = r_barrier[7] && (r_score != 16'hFFFF);
    assign w_score_next = r_score + 16'd1;
    assign w_level_up   = w_score_hit && ((w_score_next % c_speedup) == 16'd0);
    // Clamp at the floor without letting the subtraction wrap.
    assign w_div_dec    = (r_cur_div >= c_div_min + c_div_step)
                          ? (r_cur_div - c_div_step) : c_div_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_cur_div   <= c_div_init;
            r_gap_cnt   <= 4'd0;
            r_barrier   <= 8'd0;
            r_score     <= 16'd0;
            r_level     <= 4'd0;
            r_tick      <= 1'b0;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_div_cnt   <= '0;
                        r_cur_div   <= c_div_init;
                        r_gap_cnt   <= 4'd0;
                        r_barrier   <= 8'd0;
                        r_score     <= 16'd0;
                        r_level     <= 4'd0;
                        r_running   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_collision) begin
                        // Collision beats a coinciding tick: window stays as is.
                        r_state     <= S_OVER;
                        r_running   <= 1'b0;
                        r_game_over <= 1'b1;
                    end else if (!w_pause) begin
                        if (w_div_end) begin
                            r_div_cnt <= '0;
                            r_tick    <= 1'b1;
                            r_barrier <= {r_barrier[6:0], w_new_bit};
                            if (w_new_bit)
                                r_gap_cnt <= 4'd0;
                            else if (r_gap_cnt != 4'd15)
                                r_gap_cnt <= r_gap_cnt + 4'd1;
                            if (w_score_hit)
                                r_score <= w_score_next;
                            if (w_level_up) begin
                                if (r_level != 4'd15)
                                    r_level <= r_level + 4'd1;
                                // Takes effect from the interval that starts now.
                                r_cur_div <= w_div_dec;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + c_div_one;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_running   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign barrier     = r_barrier;
    assign scroll_tick = r_tick;
    assign running     = r_running;
    assign game_over   = r_game_over;
    assign score       = r_score;
    assign level       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_barrier_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrier_sched
// Purpose  : Self-checking bench for barrier_sched. A cycle-level game model
//            runs alongside the DUT and is compared on every cycle. Directed
//            scenarios pin the model with hand-computed values, then a
//            randomized phase exercises long play sessions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrier_sched;

    localparam int DIV_INIT      = 4;
    localparam int DIV_MIN       = 2;
    localparam int DIV_STEP      = 1;
    localparam int MIN_GAP       = 2;
    localparam int SPEEDUP_EVERY = 2;
    localparam int PLAYER_COL    = 6;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        jump_air = 1'b1;
    logic        rand_bit = 1'b0;
    logic        pause    = 1'b0;
    logic [7:0]  barrier;
    logic        scroll_tick;
    logic        running;
    logic        game_over;
    logic [15:0] score;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    barrier_sched #(
        .DIV_W(24), .DIV_INIT(DIV_INIT), .DIV_MIN(DIV_MIN), .DIV_STEP(DIV_STEP),
        .MIN_GAP(MIN_GAP), .SPEEDUP_EVERY(SPEEDUP_EVERY), .PLAYER_COL(PLAYER_COL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .jump_air(jump_air), .rand_bit(rand_bit),
`ifdef BARRIER_PAUSE_EN
        .pause(pause),
`endif
        .barrier(barrier), .scroll_tick(scroll_tick), .running(running),
        .game_over(game_over), .score(score), .level(level)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural game model ----------------
    // State: 0 idle, 1 run, 2 over. Time is tracked as cycles elapsed in
    // the current scroll interval rather than as a divider register.
    int m_state, m_bar, m_score, m_level, m_elapsed, m_interval, m_gap;
    bit m_tick;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int nb;
        cyc++;
        if (rst) begin
            m_state = 0; m_bar = 0; m_score = 0; m_level = 0; m_tick = 0;
            m_elapsed = 0; m_interval = DIV_INIT; m_gap = 0; m_valid = 1'b1;
        end else begin
            m_tick = 0;
            if (m_state != 1) begin
                if (start) begin
                    m_state = 1; m_bar = 0; m_score = 0; m_level = 0;
                    m_elapsed = 0; m_interval = DIV_INIT; m_gap = 0;
                end
            end else if (!pause) begin
                if (((m_bar >> PLAYER_COL) & 1) == 1 && !jump_air) begin
                    m_state = 2;
                end else begin
                    m_elapsed++;
                    if (m_elapsed >= m_interval) begin
                        m_elapsed = 0;
                        m_tick = 1;
                        nb = (rand_bit && m_gap >= MIN_GAP) ? 1 : 0;
                        if (m_bar >= 128 && m_score < 65535) begin
                            m_score++;
                            if (m_score % SPEEDUP_EVERY == 0) begin
                                m_level    = (m_level < 15) ? m_level + 1 : 15;
                                m_interval = (m_interval - DIV_STEP > DIV_MIN)
                                             ? m_interval - DIV_STEP : DIV_MIN;
                            end
                        end
                        m_bar = ((m_bar * 2) + nb) % 256;
                        m_gap = nb ? 0 : ((m_gap < 15) ? m_gap + 1 : 15);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (barrier !== 8'(m_bar) || scroll_tick !== m_tick ||
                running !== (m_state == 1) || game_over !== (m_state == 2) ||
                score !== 16'(m_score) || level !== 4'(m_level)) begin
                n_fail++;
                $display("FAIL cycle_model cyc=%0d got bar=%h tick=%b run=%b over=%b score=%0d lvl=%0d expected bar=%h tick=%b run=%b over=%b score=%0d lvl=%0d",
                         cyc, barrier, scroll_tick, running, game_over, score, level,
                         8'(m_bar), m_tick, m_state == 1, m_state == 2, m_score, m_level);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (scroll_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout got=none expected=tick within %0d cycles", budget);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [7:0] exp_bar [6];
        int exp_int [4];
        bit ok;
        int ticks, prev_t, prev_lvl;

        exp_bar = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h09};
        exp_int = '{4, 3, 2, 2};

        // Reset, then idle.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scroll_tick === 1'b1) ticks++;
        end
        check("idle_ticks", ticks, 0);
        check("idle_barrier", barrier, 0);
        check("idle_score", score, 0);
        check("idle_level", level, 0);
        check("idle_running", running, 0);

        // Start and watch the first six scroll steps.
        rand_bit = 1'b1;
        jump_air = 1'b1;
        pulse_start();
        check("start_running", running, 1);
        prev_t = 0;
        for (int k = 0; k < 6; k++) begin
            wait_tick(20, ok);
            if (!ok) break;
            check($sformatf("barrier_tick%0d", k + 1), barrier, exp_bar[k]);
            if (k > 0) check($sformatf("interval_tick%0d", k + 1), cyc - prev_t, 4);
            prev_t = cyc;
        end

        // Land on an obstacle in the player column.
        for (int i = 0; i < 60; i++) begin
            if (barrier[PLAYER_COL] === 1'b1) break;
            @(negedge clk);
        end
        check("col6_reached", barrier[PLAYER_COL], 1);
        jump_air = 1'b0;
        @(negedge clk);
        check("collide_over", game_over, 1);
        check("collide_barrier", barrier, 8'h49);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scroll_tick === 1'b1) ticks++;
        end
        check("over_ticks", ticks, 0);
        check("over_barrier_frozen", barrier, 8'h49);

        // Restart from OVER and run through three level-ups.
        jump_air = 1'b1;
        pulse_start();
        check("restart_running", running, 1);
        check("restart_score", score, 0);
        check("restart_barrier", barrier, 0);
        wait_tick(20, ok);
        prev_t = cyc;
        prev_lvl = level;
        for (int i = 0; i < 80 && ok && score < 6; i++) begin
            wait_tick(20, ok);
            if (!ok) break;
            check($sformatf("lvl_interval_l%0d", prev_lvl), cyc - prev_t, exp_int[prev_lvl]);
            prev_t = cyc;
            prev_lvl = level;
            if (score == 2) check("level_at_score2", level, 1);
            if (score == 4) check("level_at_score4", level, 2);
            if (score == 6) check("level_at_score6", level, 3);
        end
        check("score_reached6", score, 6);

        // start is ignored while running.
        pulse_start();
        check("start_in_run_keeps_score", score >= 6, 1);
        check("start_in_run_running", running, 1);

        // Reset in the middle of a run.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_barrier", barrier, 0);
        check("midrst_score", score, 0);
        check("midrst_level", level, 0);
        check("midrst_running", running, 0);
        check("midrst_tick", scroll_tick, 0);

`ifdef BARRIER_PAUSE_EN
        jump_air = 1'b1;
        pulse_start();
        for (int i = 0; i < 80; i++) begin
            if (barrier[PLAYER_COL] === 1'b1) break;
            @(negedge clk);
        end
        pause = 1'b1;
        jump_air = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (scroll_tick === 1'b1 || game_over === 1'b1) ticks++;
        end
        check("pause_no_tick_no_over", ticks, 0);
        check("pause_running", running, 1);
        pause = 1'b0;
        @(negedge clk);
        check("unpause_over", game_over, 1);
        jump_air = 1'b1;
`endif

        // Randomized play sessions.
        for (int i = 0; i < 3000; i++) begin
            rand_bit = 1'($urandom);
            jump_air = ($urandom_range(0, 9) != 0);
            start    = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 499) == 0);
`ifdef BARRIER_PAUSE_EN
            pause    = ($urandom_range(0, 7) == 0);
`endif
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
